// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - PC generator plus DEPTH-entry prefetch queue between imem and decode
module fetch_prefetch_queue #(
  parameter int XLEN = 64,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            fire;
  logic            capture;
  logic [CW:0]     occ_after_pop;

  assign fire    = out_valid & out_ready;
  assign capture = inflight & ~redirect;

  // Slots still claimed once this cycle's pop is accounted for; the in-flight fetch reserves one.
  assign occ_after_pop = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, fire};
  assign imem_req      = ~reset & ~redirect & (occ_after_pop < (CW+1)'(DEPTH));

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];
  assign fq_count  = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (redirect) begin
        // A head popped this cycle is still consumed; everything behind it is dropped.
        fetch_pc <= redirect_pc;
        inflight <= 1'b0;
        count    <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        inflight <= imem_req;
        if (imem_req) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + XLEN'(4);
        end
        if (fire) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(capture) - CW'(fire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed table-driven bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;
  localparam int XLEN = 64;
  localparam int DEPTH = 4;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  fq_count;

  int checks = 0;
  int failures = 0;

  fetch_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hDEAD_0013;
  endfunction

  // Instruction memory: data for the address presented this cycle appears next cycle.
  always @(posedge clk) imem_rdata <= instr_of(imem_addr);

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        rdy;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] pc;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic redir, input logic [63:0] rpc, input logic rdy,
                      input logic req, input logic [63:0] addr, input logic valid,
                      input logic [63:0] pc, input int cnt);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.req = req;
    v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;

    // cycle-by-cycle expectations starting at the first cycle after reset release
    addv(0, 0, 1, 1, 64'h1000, 0, 0, 0);        // 0
    addv(0, 0, 1, 1, 64'h1004, 0, 0, 0);        // 1
    addv(0, 0, 1, 1, 64'h1008, 1, 64'h1000, 1); // 2
    addv(0, 0, 1, 1, 64'h100C, 1, 64'h1004, 1); // 3
    addv(0, 0, 1, 1, 64'h1010, 1, 64'h1008, 1); // 4
    addv(0, 0, 0, 1, 64'h1014, 1, 64'h100C, 1); // 5 stall begins
    addv(0, 0, 0, 1, 64'h1018, 1, 64'h100C, 2); // 6
    addv(0, 0, 0, 0, 64'h101C, 1, 64'h100C, 3); // 7
    addv(0, 0, 0, 0, 64'h101C, 1, 64'h100C, 4); // 8 full
    addv(0, 0, 1, 1, 64'h101C, 1, 64'h100C, 4); // 9 drain
    addv(0, 0, 1, 1, 64'h1020, 1, 64'h1010, 3); // 10
    addv(0, 0, 1, 1, 64'h1024, 1, 64'h1014, 3); // 11
    addv(0, 0, 1, 1, 64'h1028, 1, 64'h1018, 3); // 12
    addv(0, 0, 1, 1, 64'h102C, 1, 64'h101C, 3); // 13
    addv(1, 64'h2000, 0, 0, 64'h1030, 1, 64'h1020, 3); // 14 redirect, 3 queued + 1 in flight
    addv(0, 0, 1, 1, 64'h2000, 0, 0, 0);        // 15
    addv(0, 0, 1, 1, 64'h2004, 0, 0, 0);        // 16
    addv(0, 0, 1, 1, 64'h2008, 1, 64'h2000, 1); // 17
    addv(0, 0, 0, 1, 64'h200C, 1, 64'h2004, 1); // 18
    addv(1, 64'h3000, 1, 0, 64'h2010, 1, 64'h2004, 2); // 19 redirect with fire
    addv(0, 0, 1, 1, 64'h3000, 0, 0, 0);        // 20
    addv(0, 0, 1, 1, 64'h3004, 0, 0, 0);        // 21
    addv(0, 0, 1, 1, 64'h3008, 1, 64'h3000, 1); // 22
    addv(1, 64'h4000, 1, 0, 64'h300C, 1, 64'h3004, 1); // 23 back-to-back redirects
    addv(1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 64'h4000, 0, 0, 0); // 24
    addv(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0); // 25
    addv(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0); // 26
    addv(0, 0, 1, 1, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1); // 27 address wraps
    addv(0, 0, 1, 1, 64'h4, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1); // 28
    addv(0, 0, 1, 1, 64'h8, 1, 64'h0, 1);       // 29
    addv(0, 0, 0, 1, 64'hC, 1, 64'h4, 1);       // 30
    addv(0, 0, 0, 1, 64'h10, 1, 64'h4, 2);      // 31

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 64'(imem_req), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(fq_count), 0);
    chk("rst_addr", imem_addr, RST_PC);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("req[%0d]", i), 64'(imem_req), 64'(vecs[i].req));
      chk($sformatf("addr[%0d]", i), imem_addr, vecs[i].addr);
      chk($sformatf("valid[%0d]", i), 64'(out_valid), 64'(vecs[i].valid));
      chk($sformatf("count[%0d]", i), 64'(fq_count), 64'(vecs[i].cnt));
      if (vecs[i].valid) begin
        chk($sformatf("pc[%0d]", i), out_pc, vecs[i].pc);
        chk($sformatf("instr[%0d]", i), 64'(out_instr), 64'(instr_of(vecs[i].pc)));
      end
      @(negedge clk);
    end

    // asynchronous reset in the middle of a cycle with entries queued and a fetch in flight
    redirect = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_req", 64'(imem_req), 0);
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_count", 64'(fq_count), 0);
    chk("midrst_addr", imem_addr, RST_PC);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("restart_req", 64'(imem_req), 1);
    chk("restart_addr", imem_addr, RST_PC);
    chk("restart_valid", 64'(out_valid), 0);
    @(negedge clk);
    #1;
    chk("restart1_valid", 64'(out_valid), 0);
    chk("restart1_count", 64'(fq_count), 0);
    chk("restart1_addr", imem_addr, RST_PC + 64'h4);
    @(negedge clk);
    #1;
    chk("restart2_valid", 64'(out_valid), 1);
    chk("restart2_pc", out_pc, RST_PC);
    chk("restart2_instr", 64'(out_instr), 64'(instr_of(RST_PC)));
    chk("restart2_count", 64'(fq_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
